// File: rtl/demux7_tdm_rx_if.sv
// ---------------------------------------------------------------------------
// demux7_tdm_rx_if
// Bundle between the 7:1 TDM link and its receiver.
//   Link side (driven by master): din, din_valid, sync
//   Frame side (driven by slave): A..G, Sel, frame_valid, sync_err, locked,
//                                 frame_cnt[CNT_W-1:0]
// master = the upstream mux / test driver, slave = the receiver.
// ---------------------------------------------------------------------------
interface demux7_tdm_rx_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             sync;
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             E;
  logic             F;
  logic             G;
  logic [2:0]       Sel;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output din, din_valid, sync,
    input  A, B, C, D, E, F, G, Sel, frame_valid, sync_err, locked, frame_cnt
  );

  modport slave (
    input  din, din_valid, sync,
    output A, B, C, D, E, F, G, Sel, frame_valid, sync_err, locked, frame_cnt
  );
endinterface

// File: rtl/demux7_tdm_rx.sv
// ---------------------------------------------------------------------------
// demux7_tdm_rx
// Receive end of a 7:1 bit-serial TDM link. Tracks the slot sequence
// (0..6), collects slots 0..5 in a shadow register and publishes the whole
// frame on A..G at once when slot 6 arrives, with a one-cycle frame_valid.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of demux7_tdm_rx_if (din/din_valid/sync in,
//            A..G, Sel, frame_valid, sync_err, locked, frame_cnt out)
// Parameters:
//   REQUIRE_SYNC : 1 = every slot-0 beat must carry sync, 0 = sync only
//                  needed to acquire lock
//   CNT_W        : width of the completed-frame counter (must match bus)
// ---------------------------------------------------------------------------
module demux7_tdm_rx #(
  parameter bit REQUIRE_SYNC = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux7_tdm_rx_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0]       LAST_SLOT = 3'd6;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [5:0]       r_shadow;
  logic [6:0]       r_frame;
  logic             r_frameValid;
  logic             r_syncErr;
  logic [CNT_W-1:0] r_frameCnt;

  // Slot tracker and frame assembler. Only valid beats advance anything;
  // the two pulse outputs fall back to 0 on every edge so they last one
  // cycle. A sync beat always restarts the frame at slot 0, which is how an
  // early sync both flags the error and resynchronises in the same beat.
  // Slot 6 is never stored: it goes straight to G together with the shadow
  // bits so A..G change atomically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= 3'd0;
      r_shadow     <= 6'd0;
      r_frame      <= 7'd0;
      r_frameValid <= 1'b0;
      r_syncErr    <= 1'b0;
      r_frameCnt   <= '0;
    end else begin
      r_frameValid <= 1'b0;
      r_syncErr    <= 1'b0;
      if (bus.din_valid) begin
        case (r_state)
          IDLE: begin
            if (bus.sync) begin
              r_shadow[0] <= bus.din;
              r_sel       <= 3'd1;
              r_state     <= RUN;
            end
          end
          RUN: begin
            if (bus.sync) begin
              if (r_sel != 3'd0) begin
                r_syncErr <= 1'b1;
              end
              r_shadow[0] <= bus.din;
              r_sel       <= 3'd1;
            end else if (r_sel == 3'd0) begin
              if (REQUIRE_SYNC) begin
                r_syncErr <= 1'b1;
                r_state   <= IDLE;
                r_sel     <= 3'd0;
              end else begin
                r_shadow[0] <= bus.din;
                r_sel       <= 3'd1;
              end
            end else if (r_sel == LAST_SLOT) begin
              r_frame      <= {r_shadow[0], r_shadow[1], r_shadow[2],
                               r_shadow[3], r_shadow[4], r_shadow[5], bus.din};
              r_frameValid <= 1'b1;
              r_frameCnt   <= r_frameCnt + CNT_ONE;
              r_sel        <= 3'd0;
            end else begin
              r_shadow[r_sel] <= bus.din;
              r_sel           <= r_sel + 3'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_sel   <= 3'd0;
          end
        endcase
      end
    end
  end

  // Outputs are straight views of registers; A is slot 0, G is slot 6.
  assign bus.A           = r_frame[6];
  assign bus.B           = r_frame[5];
  assign bus.C           = r_frame[4];
  assign bus.D           = r_frame[3];
  assign bus.E           = r_frame[2];
  assign bus.F           = r_frame[1];
  assign bus.G           = r_frame[0];
  assign bus.Sel         = r_sel;
  assign bus.frame_valid = r_frameValid;
  assign bus.sync_err    = r_syncErr;
  assign bus.locked      = (r_state == RUN);
  assign bus.frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_demux7_tdm_rx.sv
// ---------------------------------------------------------------------------
// tb_demux7_tdm_rx
// Directed bench for demux7_tdm_rx. Three receivers share one stimulus:
//   dut  : REQUIRE_SYNC=1, CNT_W=8 (main checks)
//   dut0 : REQUIRE_SYNC=0, CNT_W=8 (relaxed slot-0 rule)
//   dut2 : REQUIRE_SYNC=0, CNT_W=2 (counter wrap)
// ---------------------------------------------------------------------------
module tb_demux7_tdm_rx;

  logic clk;
  logic rst_n;

  demux7_tdm_rx_if #(.CNT_W(8)) bus  ();
  demux7_tdm_rx_if #(.CNT_W(8)) bus0 ();
  demux7_tdm_rx_if #(.CNT_W(2)) bus2 ();

  demux7_tdm_rx #(.REQUIRE_SYNC(1'b1), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  demux7_tdm_rx #(.REQUIRE_SYNC(1'b0), .CNT_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  demux7_tdm_rx #(.REQUIRE_SYNC(1'b0), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] frameMain;
  logic [6:0] frame0;
  assign frameMain = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};
  assign frame0    = {bus0.A, bus0.B, bus0.C, bus0.D, bus0.E, bus0.F, bus0.G};

  typedef struct {
    logic       dv;
    logic       sy;
    logic       d;
    logic [6:0] expFrame;
    logic       expFv;
    logic       expErr;
    logic [2:0] expSel;
    logic       expLocked;
    int         expCnt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  // Compare one value and report a named failure.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat to all receivers, then step to just after the edge.
  task automatic applyStimulus(input logic dv, input logic sy, input logic d);
    bus.din_valid  = dv;  bus.sync  = sy;  bus.din  = d;
    bus0.din_valid = dv;  bus0.sync = sy;  bus0.din = d;
    bus2.din_valid = dv;  bus2.sync = sy;  bus2.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic dv, input logic sy, input logic d,
                        input logic [6:0] f, input logic fv, input logic err,
                        input logic [2:0] sel, input logic lk, input int cnt);
    vec_t v;
    v.dv = dv; v.sy = sy; v.d = d; v.expFrame = f; v.expFv = fv;
    v.expErr = err; v.expSel = sel; v.expLocked = lk; v.expCnt = cnt;
    tbl.push_back(v);
  endtask

  // Check the main receiver against a full expected state.
  task automatic checkMain(input string tag, input logic [6:0] f,
                           input logic fv, input logic err, input logic [2:0] sel,
                           input logic lk, input int cnt);
    checkOutput({tag, " frame"},     32'(frameMain),       32'(f));
    checkOutput({tag, " fv"},        32'(bus.frame_valid), 32'(fv));
    checkOutput({tag, " err"},       32'(bus.sync_err),    32'(err));
    checkOutput({tag, " sel"},       32'(bus.Sel),         32'(sel));
    checkOutput({tag, " locked"},    32'(bus.locked),      32'(lk));
    checkOutput({tag, " cnt"},       32'(bus.frame_cnt),   32'(cnt[7:0]));
  endtask

  logic [6:0] pats [3];
  logic [6:0] f1;
  logic [6:0] f2;

  initial begin
    f1 = 7'b1011001;
    f2 = 7'b0100110;

    // IDLE ignores non-sync beats, then a clean frame.
    addVec(1, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0, 0, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 2, 1, 0);
    addVec(1, 0, 1, 0, 0, 0, 3, 1, 0);
    addVec(1, 0, 1, 0, 0, 0, 4, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 5, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 6, 1, 0);
    addVec(1, 0, 1, f1, 1, 0, 0, 1, 1);
    // Second frame with a 3-cycle stall after slot 3; stalled beats carry
    // junk sync/din that must be ignored.
    addVec(1, 1, 0, f1, 0, 0, 1, 1, 1);
    addVec(1, 0, 1, f1, 0, 0, 2, 1, 1);
    addVec(1, 0, 0, f1, 0, 0, 3, 1, 1);
    addVec(1, 0, 0, f1, 0, 0, 4, 1, 1);
    addVec(0, 1, 1, f1, 0, 0, 4, 1, 1);
    addVec(0, 0, 1, f1, 0, 0, 4, 1, 1);
    addVec(0, 1, 0, f1, 0, 0, 4, 1, 1);
    addVec(1, 0, 1, f1, 0, 0, 5, 1, 1);
    addVec(1, 0, 1, f1, 0, 0, 6, 1, 1);
    addVec(1, 0, 0, f2, 1, 0, 0, 1, 2);
    addVec(0, 0, 0, f2, 0, 0, 0, 1, 2);

    // Reset state.
    rst_n = 1'b0;
    bus.din_valid  = 0; bus.sync  = 0; bus.din  = 0;
    bus0.din_valid = 0; bus0.sync = 0; bus0.din = 0;
    bus2.din_valid = 0; bus2.sync = 0; bus2.din = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkMain("reset", 7'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Table-driven basic frames and stall.
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].dv, tbl[i].sy, tbl[i].d);
      checkMain($sformatf("vec%0d", i), tbl[i].expFrame, tbl[i].expFv,
                tbl[i].expErr, tbl[i].expSel, tbl[i].expLocked, tbl[i].expCnt);
      checkOutput($sformatf("vec%0d cnt2", i), 32'(bus2.frame_cnt),
                  32'(tbl[i].expCnt % 4));
    end

    // Early sync at slot 4: error, resync, then a good frame 1011010.
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkMain("pre-early", f2, 0, 0, 4, 1, 2);
    applyStimulus(1, 1, 1);
    checkMain("early", f2, 0, 1, 1, 1, 2);
    applyStimulus(1, 0, 0);
    checkMain("early+1", f2, 0, 0, 2, 1, 2);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    checkMain("resync frame", 7'b1011010, 1, 0, 0, 1, 3);
    checkOutput("resync cnt2", 32'(bus2.frame_cnt), 32'd3);

    // Slot-0 beat without sync: strict receiver drops lock, relaxed accepts.
    applyStimulus(1, 0, 1);
    checkMain("nosync strict", 7'b1011010, 0, 1, 0, 0, 3);
    checkOutput("nosync relaxed err", 32'(bus0.sync_err), 32'd0);
    checkOutput("nosync relaxed sel", 32'(bus0.Sel), 32'd1);
    checkOutput("nosync relaxed locked", 32'(bus0.locked), 32'd1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    checkMain("strict idle", 7'b1011010, 0, 0, 0, 0, 3);
    checkOutput("relaxed frame", 32'(frame0), 32'h55);
    checkOutput("relaxed fv", 32'(bus0.frame_valid), 32'd1);
    checkOutput("relaxed cnt", 32'(bus0.frame_cnt), 32'd4);
    checkOutput("wrap cnt2", 32'(bus2.frame_cnt), 32'd0);

    // Three back-to-back frames: frame_valid only on each 7th beat.
    pats[0] = 7'b1100101;
    pats[1] = 7'b0011010;
    pats[2] = 7'b1111111;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 7; b++) begin
        applyStimulus(1, (b == 0), pats[k][6-b]);
        checkOutput($sformatf("b2b f%0d b%0d fv", k, b),
                    32'(bus.frame_valid), 32'(b == 6));
        checkOutput($sformatf("b2b f%0d b%0d sel", k, b),
                    32'(bus.Sel), 32'((b + 1) % 7));
      end
      checkMain($sformatf("b2b f%0d", k), pats[k], 1, 0, 0, 1, 4 + k);
      checkOutput($sformatf("b2b f%0d cnt0", k), 32'(bus0.frame_cnt), 32'(5 + k));
      checkOutput($sformatf("b2b f%0d cnt2", k), 32'(bus2.frame_cnt), 32'((1 + k) % 4));
    end

    // Start frame 4, reset asynchronously at slot 2.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 1);
    checkMain("pre-reset", pats[2], 0, 0, 2, 1, 6);
    bus.din_valid = 0; bus0.din_valid = 0; bus2.din_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    checkMain("async reset", 7'd0, 0, 0, 0, 0, 0);
    checkOutput("async reset cnt0", 32'(bus0.frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    checkMain("post-reset idle", 7'd0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux7_tdm_rx.md
Name: demux7_tdm_rx

Overview:
- Receive end of the 7:1 bit-serial time-division link. A transmitter drives one of seven single-bit sources (A..G) onto a shared line, cycling slot 0..6.
- This block tracks the slot sequence, steers each received bit into its own slot register, and presents the assembled 7-bit frame atomically on outputs A..G with a one-cycle valid pulse.
- It sits directly downstream of the 7:1 mux datapath.

Parameters:
- REQUIRE_SYNC, 1, when 1 every slot-0 beat must carry sync=1; when 0, sync is only needed to acquire lock initially.
- CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din/sync qualify this cycle; low = stall, hold all state
- sync  input  1  marks the beat carrying slot 0 (bit A)
- A..G  output  1 each  registered frame bits, slot 0..6; update only on frame completion
- Sel  output  3  slot index expected on the next valid beat (0..6)
- frame_valid  output  1  one-cycle pulse, A..G just updated
- sync_err  output  1  one-cycle pulse on a framing violation
- locked  output  1  high in RUN state
- frame_cnt  output  CNT_W  completed frames, wraps to 0 after all-ones

Behaviour:
- Reset (async, rst_n=0):
  - A..G=0, Sel=0, frame_valid=0, sync_err=0, locked=0, frame_cnt=0, shadow register=0, state=IDLE.
  - Asserting reset mid-frame discards the partial frame immediately.
- Updates happen on rising clk only on beats with din_valid=1. With din_valid=0, all state holds and frame_valid/sync_err are 0.
- IDLE (hunting):
  - Valid beat with sync=0: ignored.
  - Valid beat with sync=1: shadow[0]=din, Sel=1, state=RUN.
  - sync_err is never raised in IDLE.
- RUN:
  - Valid beat with sync=0 and Sel in 1..6: shadow[Sel]=din, Sel increments.
  - Valid beat with sync=1 and Sel!=0 (early sync): sync_err pulse. Partial frame discarded; this beat is taken as slot 0: shadow[0]=din, Sel=1, stay RUN, no frame_valid.
  - Valid beat with Sel=0 and sync=1: normal slot 0 capture, Sel=1.
  - Valid beat with Sel=0, sync=0, REQUIRE_SYNC=1: sync_err pulse, beat discarded, state=IDLE, Sel=0.
  - Valid beat with Sel=0, sync=0, REQUIRE_SYNC=0: accepted as slot 0, Sel=1.
- Frame completion (valid beat at Sel=6, sync=0):
  - On that same edge: {A,B,C,D,E,F} <= shadow[0..5], G <= din.
  - frame_valid=1 for exactly the following cycle; frame_cnt increments; Sel wraps to 0.
  - Latency: the last bit is visible on G one clock after it is sampled.
- Valid beat at Sel=6 with sync=1: early-sync rule applies; no frame is emitted.
- A..G hold their last completed frame across errors, IDLE periods and stalls.
- frame_valid and sync_err are never both 1 in the same cycle.
- Back-to-back frames are supported at one beat per cycle: frame_valid pulses every 7th cycle with no bubble.
- locked = (state==RUN).

Test Plan:
- Reset then 7 contiguous valid beats, sync on beat 0, din=1,0,1,1,0,0,1 -> after the 7th edge A..G=1,0,1,1,0,0,1; frame_valid high 1 cycle; frame_cnt=1; Sel=0; locked=1.
- Same frame with din_valid=0 inserted for 3 cycles after slot 3 -> identical A..G result; frame_valid only after the slot-6 beat; Sel holds at 4 during the stall.
- Locked, then sync=1 on the slot-4 beat -> sync_err 1 cycle; Sel=1; A..G unchanged; the next 6 beats complete a new frame correctly.
- REQUIRE_SYNC=1, locked, slot-0 beat with sync=0 -> sync_err; locked=0; Sel=0. REQUIRE_SYNC=0, same stimulus -> no error, frame accepted.
- 3 back-to-back frames, then rst_n pulsed low at slot 2 of frame 4 -> all outputs 0 asynchronously; frame_cnt=0; IDLE. Non-sync beats afterwards are ignored.
- CNT_W=2, 5 consecutive frames -> frame_cnt sequence 1,2,3,0,1.
